// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for a streaming FFT.
// Each frame is written into one half of a ping-pong RAM. The other half
// is replayed in natural order with first/last/index frame markers.
module fft_bitrev_reorder #(
   parameter int unsigned FFT_N  = 1024,
   parameter int unsigned DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       in_first,
   input  logic signed [DATA_W-1:0]   xb_re,
   input  logic signed [DATA_W-1:0]   xb_im,
   output logic signed [DATA_W-1:0]   X_re,
   output logic signed [DATA_W-1:0]   X_im,
   output logic                       out_valid,
   output logic                       out_first,
   output logic                       out_last,
   output logic [$clog2(FFT_N)-1:0]   out_index
);

   localparam int unsigned LOG_N  = $clog2(FFT_N);
   localparam int unsigned WORD_W = 2 * DATA_W;
   localparam int unsigned DEPTH  = 2 * FFT_N;
   localparam logic [LOG_N-1:0] LAST = LOG_N'(FFT_N - 1);

   // Bank select is the address MSB: {bank, bin}
   logic [WORD_W-1:0] ram [DEPTH];

   logic [LOG_N-1:0]  wr_cnt_q, wr_cnt_d;
   logic [LOG_N-1:0]  rd_cnt_q, rd_cnt_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_active_q, rd_active_d;
   logic              wr_en_c, rd_en_c, swap_c;
   logic [LOG_N-1:0]  wr_addr_c;

   logic signed [DATA_W-1:0] re_q, im_q;
   logic [LOG_N-1:0]         idx_q;
   logic                     valid_q, first_q, last_q;

   function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
      logic [LOG_N-1:0] r;
      r = '0;
      for (int i = 0; i < int'(LOG_N); i++) r[i] = a[int'(LOG_N) - 1 - i];
      return r;
   endfunction

   // Next-state for write counter, bank swap and read sequencer
   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_cnt_d    = rd_cnt_q;
      rd_active_d = rd_active_q;
      swap_c      = 1'b0;
      wr_addr_c   = bitrev(wr_cnt_q);
      wr_en_c     = enable & ~rst;
      rd_en_c     = enable & rd_active_q;

      if (enable) begin
         if (in_first) begin
            // Resync: any partial frame is dropped without a swap
            wr_addr_c = '0;
            wr_cnt_d  = LOG_N'(1);
         end else begin
            wr_cnt_d = wr_cnt_q + LOG_N'(1);
            if (wr_cnt_q == LAST) begin
               swap_c    = 1'b1;
               wr_bank_d = ~wr_bank_q;
            end
         end
      end

      if (rd_en_c) begin
         rd_cnt_d = rd_cnt_q + LOG_N'(1);
         if (rd_cnt_q == LAST) rd_active_d = 1'b0;
      end

      // A completed frame restarts the reader on the freshly filled bank
      if (swap_c) begin
         rd_active_d = 1'b1;
         rd_cnt_d    = '0;
      end
   end

   // Frame RAM write port (contents intentionally not reset)
   always_ff @(posedge clk) begin
      if (wr_en_c) ram[{wr_bank_q, wr_addr_c}] <= {xb_re, xb_im};
   end

   // Control state and registered natural-order output
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_active_q <= 1'b0;
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         re_q        <= '0;
         im_q        <= '0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_active_q <= rd_active_d;
         valid_q     <= rd_en_c;
         first_q     <= rd_en_c & (rd_cnt_q == '0);
         last_q      <= rd_en_c & (rd_cnt_q == LAST);
         if (rd_en_c) begin
            {re_q, im_q} <= ram[{~wr_bank_q, rd_cnt_q}];
            idx_q        <= rd_cnt_q;
         end
      end
   end

   assign X_re      = re_q;
   assign X_im      = im_q;
   assign out_valid = valid_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign out_index = idx_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: an 8-point and a 1024-point instance share
// one stimulus bus; a frame-level model predicts every output cycle.
module tb_fft_bitrev_reorder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic first = 1'b0;
   logic sel = 1'b0;
   logic signed [15:0] re = '0, im = '0;
   logic en_a, en_b;

   logic signed [15:0] a_re, a_im, b_re, b_im;
   logic a_v, a_f, a_l, b_v, b_f, b_l;
   logic [2:0] a_idx;
   logic [9:0] b_idx;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   assign en_a = en & ~sel;
   assign en_b = en & sel;

   fft_bitrev_reorder #(.FFT_N(8), .DATA_W(16)) u_a (
      .clk(clk), .rst(rst), .enable(en_a), .in_first(first),
      .xb_re(re), .xb_im(im), .X_re(a_re), .X_im(a_im),
      .out_valid(a_v), .out_first(a_f), .out_last(a_l), .out_index(a_idx));

   fft_bitrev_reorder #(.FFT_N(1024), .DATA_W(16)) u_b (
      .clk(clk), .rst(rst), .enable(en_b), .in_first(first),
      .xb_re(re), .xb_im(im), .X_re(b_re), .X_im(b_im),
      .out_valid(b_v), .out_first(b_f), .out_last(b_l), .out_index(b_idx));

   // ---------------- frame-level reference model ----------------
   logic signed [15:0] fb_re [1024], fb_im [1024];
   logic signed [15:0] rf_re [1024], rf_im [1024];
   int  cnt = 0, rd_idx = 0;
   bit  rd_on = 0;
   bit  exp_v = 0, exp_f = 0, exp_l = 0;
   logic signed [15:0] exp_re = '0, exp_im = '0;
   int  exp_idx = 0;

   function automatic int brev(input int p, input int lb);
      int r = 0;
      for (int b = 0; b < lb; b++) if (((p >> b) & 1) != 0) r += 1 << (lb - 1 - b);
      return r;
   endfunction

   always @(posedge clk) begin
      int n, lb, p;
      n  = sel ? 1024 : 8;
      lb = sel ? 10 : 3;
      if (rst) begin
         cnt = 0; rd_on = 0; rd_idx = 0;
         exp_v = 0; exp_f = 0; exp_l = 0; exp_re = '0; exp_im = '0; exp_idx = 0;
      end else begin
         exp_v = 0; exp_f = 0; exp_l = 0;
         if (en && rd_on) begin
            exp_v = 1; exp_re = rf_re[rd_idx]; exp_im = rf_im[rd_idx];
            exp_idx = rd_idx; exp_f = (rd_idx == 0); exp_l = (rd_idx == n - 1);
            rd_idx++;
            if (rd_idx == n) rd_on = 0;
         end
         if (en) begin
            if (first) cnt = 0;
            p = brev(cnt, lb);
            fb_re[p] = re; fb_im[p] = im;
            cnt++;
            if (cnt == n) begin
               for (int k = 0; k < n; k++) begin rf_re[k] = fb_re[k]; rf_im[k] = fb_im[k]; end
               rd_on = 1; rd_idx = 0; cnt = 0;
            end
         end
      end
   end

   // ---------------- comparison ----------------
   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   int cap_re[$], cap_im[$], cap_idx[$];
   bit cap_first[$], cap_last[$];
   int vcnt_a = 0, last_b = 0;

   always @(negedge clk) begin
      chk("out_valid", sel ? int'(b_v) : int'(a_v), int'(exp_v));
      chk("out_first", sel ? int'(b_f) : int'(a_f), int'(exp_f));
      chk("out_last",  sel ? int'(b_l) : int'(a_l), int'(exp_l));
      chk("out_index", sel ? int'(b_idx) : int'(a_idx), exp_idx);
      chk("X_re",      sel ? int'(b_re) : int'(a_re), int'(exp_re));
      chk("X_im",      sel ? int'(b_im) : int'(a_im), int'(exp_im));
      if (!sel && a_v) begin
         cap_re.push_back(int'(a_re)); cap_im.push_back(int'(a_im));
         cap_idx.push_back(int'(a_idx));
         cap_first.push_back(a_f); cap_last.push_back(a_l);
         vcnt_a++;
      end
      if (sel && b_v && b_l) last_b++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit e, input bit f, input int r, input int i);
      @(posedge clk); #2;
      en = e; first = f; re = 16'(r); im = 16'(i);
   endtask

   task automatic do_reset(input bit s);
      @(posedge clk); #2;
      rst = 1'b1; en = 1'b0; first = 1'b0;
      @(posedge clk); #2;
      sel = s;
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic frame8(input int off, input int gap);
      for (int j = 0; j < 8; j++) begin
         step(1'b1, j == 0, off + j, -(off + j));
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 0, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic clear_cap();
      cap_re.delete(); cap_im.delete(); cap_idx.delete();
      cap_first.delete(); cap_last.delete();
   endtask

   // Hand-derived natural-order sequence for inputs j=0..7 in bit-reversed order
   task automatic check_literal8();
      int lit[8];
      lit = '{0, 4, 2, 6, 1, 5, 3, 7};
      chk("lit_count", cap_re.size(), 8);
      for (int k = 0; k < 8 && k < cap_re.size(); k++) begin
         chk("lit_re",    cap_re[k], lit[k]);
         chk("lit_im",    cap_im[k], -lit[k]);
         chk("lit_idx",   cap_idx[k], k);
         chk("lit_first", int'(cap_first[k]), int'(k == 0));
         chk("lit_last",  int'(cap_last[k]), int'(k == 7));
      end
   endtask

   initial begin
      do_reset(1'b0);
      chk("rst_valid", int'(a_v), 0);
      chk("rst_index", int'(a_idx), 0);
      chk("rst_re", int'(a_re), 0);

      // single frame, continuous enable
      clear_cap();
      frame8(0, 0);
      frame8(900, 0);
      idle(3);
      check_literal8();

      // three back-to-back frames
      do_reset(1'b0);
      frame8(0, 0); frame8(100, 0); frame8(200, 0); frame8(300, 0);
      idle(3);

      // enable every third cycle
      do_reset(1'b0);
      clear_cap();
      frame8(0, 2);
      frame8(50, 2);
      idle(4);
      check_literal8();

      // resync in the middle of frame 2
      do_reset(1'b0);
      vcnt_a = 0;
      frame8(0, 0);
      for (int j = 0; j < 4; j++) step(1'b1, j == 0, 400 + j, -(400 + j));
      frame8(500, 0);
      frame8(600, 0);
      idle(3);
      chk("resync_outputs", vcnt_a, 16);

      // reset in the middle of a readout
      do_reset(1'b0);
      frame8(0, 0);
      for (int j = 0; j < 4; j++) step(1'b1, j == 0, 700 + j, -(700 + j));
      @(posedge clk); @(negedge clk);
      chk("midread_valid", int'(a_v), 1);
      chk("midread_index", int'(a_idx), 3);
      do_reset(1'b0);
      @(negedge clk);
      chk("postrst_valid", int'(a_v), 0);
      chk("postrst_re", int'(a_re), 0);
      chk("postrst_im", int'(a_im), 0);
      chk("postrst_index", int'(a_idx), 0);
      vcnt_a = 0;
      frame8(800, 0);
      chk("postrst_quiet", vcnt_a, 0);
      frame8(900, 0);
      idle(3);
      chk("postrst_resume", vcnt_a, 8);

      // 1024-point random frames, continuous enable
      do_reset(1'b1);
      last_b = 0;
      for (int f = 0; f < 4; f++)
         for (int j = 0; j < 1024; j++)
            step(1'b1, j == 0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      idle(3);
      chk("n1024_last_count", last_b, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
